exe_muldiv_iter: RTL
====================

Name: exe_muldiv_iter

Overview:
- Parametrised multi-cycle RV M-extension unit serving the EXE stage: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Replaces the single-cycle combinational multiplier and the fixed-width divider path.
- Adds XLEN and radix generalisation, a valid/ready handshake, early-out special cases and pipeline flush.
- Sits between EXE operand selection (forwarded operands) and the EXE-to-LSU result mux; the pipeline stalls while a request is in flight.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration; 1, 2 or 4; must divide XLEN.
- EARLY_OUT, 1, 1 enables the single-cycle divide-by-zero and signed-overflow path.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_opr1  in  XLEN  rs1 value (multiplicand/dividend)
- req_opr2  in  XLEN  rs2 value (multiplier/divisor)
- req_rd_addr  in  5  destination register tag
- flush  in  1  kill in-flight operation
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_result  out  XLEN  result
- rsp_rd_addr  out  5  tag of result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1; rsp_valid=0; rsp_result=0; rsp_rd_addr=0; busy=0; all internal registers cleared.
- FSM states: IDLE, CALC, FIX, DONE. N = XLEN/BITS_PER_CYCLE.
- Acceptance is req_valid & req_ready at the edge. req_ready = (state==IDLE) & ~flush.
- From IDLE on acceptance: latch op, tag and operand signs. Latch |opr1| and |opr2| for signed ops; unsigned ops keep raw operands. Load counter = N-1. Go to CALC.
  - Exception: EARLY_OUT=1 with a div/rem op and (opr2==0, or signed op with opr1==MIN_INT and opr2==all-ones): load the special result directly and go to DONE.
- CALC:
  - Multiply: shift-add of BITS_PER_CYCLE multiplier bits per cycle into a 2*XLEN accumulator.
  - Divide: restoring division, BITS_PER_CYCLE quotient bits per cycle.
  - Counter decrements each cycle; at counter==0 go to FIX.
- FIX (1 cycle):
  - Apply sign correction. Product is negated if the signs differ. MULHSU treats only opr1 as signed; MULHU and DIVU/REMU apply no correction.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - Select the low half (MUL) or high half (MULH*), or quotient/remainder. Register into rsp_result. Go to DONE.
- DONE: rsp_valid=1. result and tag are held stable while rsp_ready=0. On rsp_ready: go to IDLE. A new request can be accepted no earlier than the following cycle.
- Latency: acceptance at edge T gives rsp_valid=1 from cycle T+N+2 (T+34 for XLEN=32, BITS_PER_CYCLE=1). The early-out path gives rsp_valid from T+1.
- Special results (RISC-V):
  - x/0: quotient = all-ones; remainder = x.
  - MIN_INT/-1 (signed): quotient = MIN_INT; remainder = 0.
  - With EARLY_OUT=0 these same values must still be produced, at full latency.
- Flush: in any state, next state=IDLE and rsp_valid=0 on the next cycle; partial and pending results are discarded. A flush in the same cycle as req_valid accepts nothing. A flush in the same cycle as a rsp handshake still counts the handshake as completed.
- No arithmetic overflow of internal widths: the accumulator is 2*XLEN, the partial remainder is XLEN+1.
- Async reset mid-operation returns to the reset values immediately.

Test Plan:
- MUL 7 * 0xFFFFFFFD, rsp_ready=1 → rsp_result=0xFFFFFFEB, rsp_valid first at T+34, req_ready=0 from T+1 to T+34.
- MULH 0x80000000*0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF; MULHU same operands → 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIV 5/0 → 0xFFFFFFFF at T+1; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Backpressure and flush:
  - rsp_ready=0 for 5 cycles in DONE → rsp_result and rsp_rd_addr stable, req_ready=0.
  - flush at T+10 of a DIV → rsp_valid never rises, req_ready=1 at T+11.
  - A new MUL issued afterward returns a correct result.
- Regression at parameter corners: XLEN=64 with BITS_PER_CYCLE=4 on random ops vs a reference model → exact match; latency 18 cycles.

Source files
------------

// File: rtl/exe_muldiv_iter.sv
// Iterative RV M-extension unit for the EXE stage. Multiplies by shift-add and
// divides by restoring division, retiring BITS_PER_CYCLE bits per iteration.
// Operands are reduced to magnitudes on entry and the sign is restored in FIX.
module exe_muldiv_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int EARLY_OUT      = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_opr1,
    input  logic [XLEN-1:0] req_opr2,
    input  logic [4:0]      req_rd_addr,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic [4:0]      rsp_rd_addr,
    output logic            busy
);
    localparam int BPC = BITS_PER_CYCLE;
    localparam int N   = XLEN / BPC;
    localparam int CW  = $clog2(N);

    localparam logic [CW-1:0]     CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]     CNT_ZERO = CW'(0);
    localparam logic [XLEN-1:0]   ZERO_X   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN:0]     ZERO_X1  = {(XLEN+1){1'b0}};
    localparam logic [2*XLEN-1:0] ZERO_2X  = {(2*XLEN){1'b0}};
    localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [BPC-1:0]    ZERO_B   = {BPC{1'b0}};
    localparam logic [XLEN+BPC-1:0] ZERO_XB = {(XLEN+BPC){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [2:0]          op_r;
    logic                neg1_r, neg2_r, div0_r;
    logic [XLEN-1:0]     a_r;          // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_r;        // product accumulator / quotient in low half
    logic [XLEN:0]       rem_r;        // partial remainder
    logic [CW-1:0]       cnt_r;
    logic [XLEN-1:0]     rsp_result_r;
    logic [4:0]          rsp_rd_addr_r;

    logic                accept_s, sgn1_s, sgn2_s, div0_s, ovf_s, early_s;
    logic [XLEN-1:0]     abs1_s, abs2_s, early_res_s;
    logic [XLEN+BPC-1:0] mul_pp_s, mul_sum_s;
    logic [2*XLEN-1:0]   mul_acc_s, prod_s;
    logic [XLEN:0]       div_rem_s;
    logic [XLEN-1:0]     div_quo_s, quo_fix_s, rem_fix_s, fix_res_s;

    // Two's-complement magnitude of a value that may be signed.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        if (sgn && v[XLEN-1]) begin
            r = ~v + ONE_X;
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign req_ready   = (state_r == ST_IDLE) & ~flush;
    assign rsp_valid   = (state_r == ST_DONE);
    assign busy        = (state_r != ST_IDLE);
    assign rsp_result  = rsp_result_r;
    assign rsp_rd_addr = rsp_rd_addr_r;
    assign accept_s    = req_valid & req_ready;

    // Request decode: operand signedness, special divide cases and their results.
    always_comb begin
        sgn1_s = 1'b0;
        sgn2_s = 1'b0;
        if (req_op[2]) begin
            sgn1_s = ~req_op[0];
            sgn2_s = ~req_op[0];
        end else begin
            sgn1_s = (req_op[1:0] != 2'b11);
            sgn2_s = ~req_op[1];
        end
        abs1_s  = abs_val(req_opr1, sgn1_s);
        abs2_s  = abs_val(req_opr2, sgn2_s);
        div0_s  = (req_opr2 == ZERO_X);
        ovf_s   = sgn1_s & (req_opr1 == MIN_INT) & (req_opr2 == ALL_ONES);
        early_s = (EARLY_OUT != 0) && req_op[2] && (div0_s || ovf_s);
        if (req_op[1]) begin
            early_res_s = div0_s ? req_opr1 : ZERO_X;
        end else begin
            early_res_s = div0_s ? ALL_ONES : MIN_INT;
        end
    end

    // One multiply iteration: add multiplicand times the low multiplier bits, shift right.
    always_comb begin
        mul_pp_s = ZERO_XB;
        for (int i = 0; i < BPC; i++) begin
            if (acc_r[i]) begin
                mul_pp_s = mul_pp_s + ({ZERO_B, a_r} << i);
            end else begin
                mul_pp_s = mul_pp_s;
            end
        end
        mul_sum_s = {ZERO_B, acc_r[2*XLEN-1:XLEN]} + mul_pp_s;
        mul_acc_s = {mul_sum_s, acc_r[XLEN-1:BPC]};
    end

    // One restoring-division iteration producing BPC quotient bits.
    always_comb begin
        div_rem_s = rem_r;
        div_quo_s = acc_r[XLEN-1:0];
        for (int i = 0; i < BPC; i++) begin
            div_rem_s = {div_rem_s[XLEN-1:0], div_quo_s[XLEN-1]};
            div_quo_s = {div_quo_s[XLEN-2:0], 1'b0};
            if (div_rem_s >= {1'b0, a_r}) begin
                div_rem_s    = div_rem_s - {1'b0, a_r};
                div_quo_s[0] = 1'b1;
            end else begin
                div_rem_s = div_rem_s;
            end
        end
    end

    // Sign correction and result selection; a zero divisor forces an all-ones quotient.
    always_comb begin
        prod_s    = (neg1_r ^ neg2_r) ? (~acc_r + ONE_2X) : acc_r;
        quo_fix_s = div0_r ? ALL_ONES :
                    ((neg1_r ^ neg2_r) ? (~acc_r[XLEN-1:0] + ONE_X) : acc_r[XLEN-1:0]);
        rem_fix_s = neg1_r ? (~rem_r[XLEN-1:0] + ONE_X) : rem_r[XLEN-1:0];
        case (op_r)
            3'd0:                fix_res_s = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    fix_res_s = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:          fix_res_s = quo_fix_s;
            3'd6, 3'd7:          fix_res_s = rem_fix_s;
            default:             fix_res_s = ZERO_X;
        endcase
    end

    // Next-state logic; flush overrides everything and returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = accept_s ? (early_s ? ST_DONE : ST_CALC) : ST_IDLE;
                ST_CALC: state_nxt_s = (cnt_r == CNT_ZERO) ? ST_FIX : ST_CALC;
                ST_FIX:  state_nxt_s = ST_DONE;
                ST_DONE: state_nxt_s = rsp_ready ? ST_IDLE : ST_DONE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, iteration registers and registered result/tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r          <= 3'd0;
            neg1_r        <= 1'b0;
            neg2_r        <= 1'b0;
            div0_r        <= 1'b0;
            a_r           <= ZERO_X;
            acc_r         <= ZERO_2X;
            rem_r         <= ZERO_X1;
            cnt_r         <= CNT_ZERO;
            rsp_result_r  <= ZERO_X;
            rsp_rd_addr_r <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r          <= req_op;
                        neg1_r        <= sgn1_s & req_opr1[XLEN-1];
                        neg2_r        <= sgn2_s & req_opr2[XLEN-1];
                        div0_r        <= div0_s;
                        rsp_rd_addr_r <= req_rd_addr;
                        cnt_r         <= CNT_LAST;
                        rem_r         <= ZERO_X1;
                        if (req_op[2]) begin
                            a_r   <= abs2_s;
                            acc_r <= {ZERO_X, abs1_s};
                        end else begin
                            a_r   <= abs1_s;
                            acc_r <= {ZERO_X, abs2_s};
                        end
                        if (early_s) begin
                            rsp_result_r <= early_res_s;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (op_r[2]) begin
                        acc_r <= {ZERO_X, div_quo_s};
                        rem_r <= div_rem_s;
                    end else begin
                        acc_r <= mul_acc_s;
                    end
                end
                ST_FIX: begin
                    rsp_result_r <= fix_res_s;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
